// File: rtl/conv_pkg.sv
// Sizing helpers and saturation bounds shared by the streaming 2-D convolution blocks.
package conv_pkg;

    function automatic int acc_width(input int word_w, input int ksize);
        return 2 * word_w + $clog2(ksize * ksize);
    endfunction

    function automatic int out_count(input int img, input int ksize, input int stride);
        return (img - ksize) / stride + 1;
    endfunction

    function automatic int cnt_width(input int img);
        return (img > 1) ? $clog2(img) : 1;
    endfunction

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/conv_window_buffer.sv
// KSIZE-1 row line buffer feeding a KSIZE x KSIZE sliding window; the window's
// bottom-right element is the most recently written pixel.
module conv_window_buffer
    import conv_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int KSIZE  = 5,
    parameter int IMG    = 36
) (
    input  logic                            clk,
    input  logic                            en,
    input  logic [cnt_width(IMG)-1:0]       col,
    input  logic signed [WORD_W-1:0]        pix,
    output logic [KSIZE*KSIZE*WORD_W-1:0]   window
);

    logic signed [WORD_W-1:0] win_q  [KSIZE][KSIZE];
    logic signed [WORD_W-1:0] win_d  [KSIZE][KSIZE];
    logic signed [WORD_W-1:0] column [KSIZE];

    generate
        if (KSIZE > 1) begin : g_lines
            // line_q[0] holds the oldest row; each write shifts the column up one row.
            logic signed [WORD_W-1:0] line_q [KSIZE-1][IMG];

            always_ff @(posedge clk) begin
                if (en) begin
                    for (int unsigned k = 0; k < KSIZE - 2; k++) begin
                        line_q[k][col] <= line_q[k+1][col];
                    end
                    line_q[KSIZE-2][col] <= pix;
                end
            end

            always_comb begin
                for (int unsigned k = 0; k < KSIZE - 1; k++) begin
                    column[k] = line_q[k][col];
                end
                column[KSIZE-1] = pix;
            end
        end else begin : g_nolines
            always_comb column[0] = pix;
        end
    endgenerate

    always_comb begin
        win_d = win_q;
        for (int unsigned i = 0; i < KSIZE; i++) begin
            for (int unsigned j = 0; j < KSIZE - 1; j++) begin
                win_d[i][j] = win_q[i][j+1];
            end
            win_d[i][KSIZE-1] = column[i];
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            win_q <= win_d;
        end
    end

    always_comb begin
        window = '0;
        for (int unsigned i = 0; i < KSIZE; i++) begin
            for (int unsigned j = 0; j < KSIZE; j++) begin
                window[(i*KSIZE+j)*WORD_W +: WORD_W] = win_q[i][j];
            end
        end
    end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming 2-D convolution: raster pixels in, saturated (optionally ReLU'd)
// window sums out through a two-stage multiply / accumulate pipeline.
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int KSIZE  = 5,
    parameter int IMG    = 36,
    parameter int STRIDE = 1,
    parameter int OUT_W  = 2 * WORD_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [KSIZE*KSIZE*WORD_W-1:0]  weight_value,
    input  logic                           relu_en,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [WORD_W-1:0]       data_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [OUT_W-1:0]        data_out,
    output logic                           out_last
);

    localparam int   KK      = KSIZE * KSIZE;
    localparam int   PROD_W  = 2 * WORD_W;
    localparam int   ACC_W   = acc_width(WORD_W, KSIZE);
    localparam int   MW      = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam int   CW      = cnt_width(IMG);
    localparam int   N       = out_count(IMG, KSIZE, STRIDE);
    localparam int   LAST_RC = (KSIZE - 1) + (N - 1) * STRIDE;
    localparam logic ALIGN   = 1'((KSIZE - 1) % 2);
    localparam logic signed [MW-1:0] SAT_HI = MW'(sat_max(OUT_W));
    localparam logic signed [MW-1:0] SAT_LO = MW'(sat_min(OUT_W));

    logic [CW-1:0]            row_q, row_d, col_q, col_d;
    logic [KK*WORD_W-1:0]     w_q, w_d;
    logic                     relu_q, relu_d;
    logic                     win_vld_q, win_vld_d, win_last_q, win_last_d;
    logic signed [PROD_W-1:0] prod_q [KK];
    logic signed [PROD_W-1:0] prod_d [KK];
    logic                     prod_vld_q, prod_vld_d, prod_last_q, prod_last_d;
    logic                     prod_relu_q, prod_relu_d;
    logic                     out_vld_q, out_vld_d, out_last_q, out_last_d;
    logic signed [OUT_W-1:0]  dout_q, dout_d;

    logic [KK*WORD_W-1:0]     window;
    logic                     adv, accept, win_ok;
    logic signed [ACC_W-1:0]  acc;
    logic signed [MW-1:0]     acc_ext;
    logic signed [OUT_W-1:0]  result;

    conv_window_buffer #(
        .WORD_W (WORD_W),
        .KSIZE  (KSIZE),
        .IMG    (IMG)
    ) u_window (
        .clk    (clk),
        .en     (accept),
        .col    (col_q),
        .pix    (data_in),
        .window (window)
    );

    always_comb begin
        adv      = !(out_vld_q && !out_ready);
        in_ready = adv && !rst;
        accept   = in_valid && in_ready;
        win_ok   = (row_q >= CW'(KSIZE - 1)) && (col_q >= CW'(KSIZE - 1))
                && ((STRIDE == 1) || ((row_q[0] == ALIGN) && (col_q[0] == ALIGN)));

        acc = '0;
        for (int unsigned k = 0; k < KK; k++) begin
            acc = acc + ACC_W'(prod_q[k]);
        end
        acc_ext = MW'(acc);
        if (acc_ext > SAT_HI)      result = SAT_HI[OUT_W-1:0];
        else if (acc_ext < SAT_LO) result = SAT_LO[OUT_W-1:0];
        else                       result = acc_ext[OUT_W-1:0];
        if (prod_relu_q && result[OUT_W-1]) result = '0;

        row_d       = row_q;
        col_d       = col_q;
        w_d         = w_q;
        relu_d      = relu_q;
        win_vld_d   = win_vld_q;
        win_last_d  = win_last_q;
        prod_d      = prod_q;
        prod_vld_d  = prod_vld_q;
        prod_last_d = prod_last_q;
        prod_relu_d = prod_relu_q;
        out_vld_d   = out_vld_q;
        out_last_d  = out_last_q;
        dout_d      = dout_q;

        if (accept) begin
            if ((row_q == '0) && (col_q == '0)) begin
                w_d    = weight_value;
                relu_d = relu_en;
            end
            if (col_q == CW'(IMG - 1)) begin
                col_d = '0;
                row_d = (row_q == CW'(IMG - 1)) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        // relu travels with the products so a frame boundary mid-pipeline keeps each frame's setting.
        if (adv) begin
            win_vld_d   = accept && win_ok;
            win_last_d  = accept && win_ok && (row_q == CW'(LAST_RC)) && (col_q == CW'(LAST_RC));
            prod_vld_d  = win_vld_q;
            prod_last_d = win_last_q;
            prod_relu_d = relu_q;
            for (int unsigned k = 0; k < KK; k++) begin
                prod_d[k] = PROD_W'($signed(w_q[k*WORD_W +: WORD_W]))
                          * PROD_W'($signed(window[k*WORD_W +: WORD_W]));
            end
            out_vld_d  = prod_vld_q;
            out_last_d = prod_last_q;
            if (prod_vld_q) dout_d = result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q       <= '0;
            col_q       <= '0;
            w_q         <= '0;
            relu_q      <= 1'b0;
            win_vld_q   <= 1'b0;
            win_last_q  <= 1'b0;
            prod_q      <= '{default: '0};
            prod_vld_q  <= 1'b0;
            prod_last_q <= 1'b0;
            prod_relu_q <= 1'b0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            dout_q      <= '0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            w_q         <= w_d;
            relu_q      <= relu_d;
            win_vld_q   <= win_vld_d;
            win_last_q  <= win_last_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            prod_last_q <= prod_last_d;
            prod_relu_q <= prod_relu_d;
            out_vld_q   <= out_vld_d;
            out_last_q  <= out_last_d;
            dout_q      <= dout_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_last  = out_last_q;
    assign data_out  = dout_q;

endmodule

// File: tb/tb_conv2d_stream.sv
// Directed checks for conv2d_stream on a 6x6 image with a 3x3 kernel: uniform
// frames from a vector table, then stall, mid-frame reset and stride-2 sequences.
module tb_conv2d_stream;

    localparam int WW   = 8;
    localparam int K    = 3;
    localparam int IMG  = 6;
    localparam int OW   = 16;
    localparam int NPIX = IMG * IMG;
    localparam int NOUT = 16;
    localparam int NV   = 8;

    typedef struct {
        logic signed [WW-1:0] w;
        logic signed [WW-1:0] p;
        logic                 relu;
        logic signed [OW-1:0] exp;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [K*K*WW-1:0]    weight_value = '0;
    logic                 relu_en = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 sel2 = 1'b0;
    logic                 out_ready = 1'b1;
    logic signed [WW-1:0] data_in = '0;
    logic                 iv1, iv2;
    logic                 in_ready1, out_valid1, out_last1;
    logic                 in_ready2, out_valid2, out_last2;
    logic signed [OW-1:0] data_out1, data_out2;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int first_out_cyc = -1;
    int last_acc_cyc = 0;
    int acc14 = 0;

    logic signed [OW-1:0] q1_data[$], q2_data[$];
    logic                 q1_last[$], q2_last[$];

    assign iv1 = in_valid && !sel2;
    assign iv2 = in_valid && sel2;

    conv2d_stream #(
        .WORD_W (WW), .KSIZE (K), .IMG (IMG), .STRIDE (1), .OUT_W (OW)
    ) dut1 (
        .clk (clk), .rst (rst), .weight_value (weight_value), .relu_en (relu_en),
        .in_valid (iv1), .in_ready (in_ready1), .data_in (data_in),
        .out_valid (out_valid1), .out_ready (out_ready), .data_out (data_out1),
        .out_last (out_last1)
    );

    conv2d_stream #(
        .WORD_W (WW), .KSIZE (K), .IMG (IMG), .STRIDE (2), .OUT_W (OW)
    ) dut2 (
        .clk (clk), .rst (rst), .weight_value (weight_value), .relu_en (relu_en),
        .in_valid (iv2), .in_ready (in_ready2), .data_in (data_in),
        .out_valid (out_valid2), .out_ready (1'b1), .data_out (data_out2),
        .out_last (out_last2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready) begin
            q1_data.push_back(data_out1);
            q1_last.push_back(out_last1);
        end
        if (!rst && out_valid2) begin
            q2_data.push_back(data_out2);
            q2_last.push_back(out_last2);
        end
        if (out_valid1 && first_out_cyc < 0) first_out_cyc = cyc;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic signed [WW-1:0] p);
        logic ok;
        int   guard;
        ok = 1'b0;
        guard = 0;
        in_valid = 1'b1;
        data_in  = p;
        while (!ok && guard < 100) begin
            @(negedge clk);
            ok = sel2 ? in_ready2 : in_ready1;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!ok) check("push_timeout", 0, 1);
        last_acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_out_valid", out_valid1, 0);
        check("rst_out_last", out_last1, 0);
        check("rst_data_out", data_out1, 0);
        check("rst_in_ready", in_ready1, 0);
        check("rst_out_valid2", out_valid2, 0);
        first_out_cyc = -1;
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready1, 1);
    endtask

    task automatic drain();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic send_uniform(input vec_t v, input logic measure);
        weight_value = {K*K{v.w}};
        relu_en      = v.relu;
        for (int i = 0; i < NPIX; i++) begin
            push(v.p);
            if (i == 0) begin
                // Garbage after the first pixel: the frame must keep its latched values.
                weight_value = {K*K{~v.w}};
                relu_en      = ~v.relu;
            end
            if (measure && i == 14) acc14 = last_acc_cyc;
        end
    endtask

    task automatic send_ramp();
        weight_value = {K*K{8'sd1}};
        relu_en      = 1'b0;
        for (int r = 0; r < IMG; r++) begin
            for (int c = 0; c < IMG; c++) begin
                push(WW'(r * IMG + c));
            end
        end
    endtask

    function automatic int ramp_exp(input int r0, input int c0);
        return 9 * (IMG * r0 + c0) + 63;
    endfunction

    task automatic check_ramp_q1(input string tag);
        logic signed [OW-1:0] d;
        logic                 l;
        check({tag, "_count"}, q1_data.size(), NOUT);
        for (int i = 0; i < NOUT; i++) begin
            if (q1_data.size() > 0) begin
                d = q1_data.pop_front();
                l = q1_last.pop_front();
                check($sformatf("%s_out%0d", tag, i), d, ramp_exp(i / 4, i % 4));
                check($sformatf("%s_last%0d", tag, i), l, (i == NOUT - 1) ? 1 : 0);
            end
        end
    endtask

    initial begin
        vec_t                 tbl[NV];
        logic signed [OW-1:0] d, held;
        logic                 l;
        int                   g;

        tbl[0] = '{w: 8'sd1,   p: 8'sd1,   relu: 1'b0, exp: 16'sd9};
        tbl[1] = '{w: 8'sd127, p: 8'sd127, relu: 1'b0, exp: 16'sd32767};
        tbl[2] = '{w: 8'sh80,  p: 8'sd127, relu: 1'b0, exp: 16'sh8000};
        tbl[3] = '{w: -8'sd1,  p: 8'sd1,   relu: 1'b1, exp: 16'sd0};
        tbl[4] = '{w: -8'sd1,  p: 8'sd1,   relu: 1'b0, exp: -16'sd9};
        tbl[5] = '{w: 8'sd2,   p: -8'sd3,  relu: 1'b0, exp: -16'sd54};
        tbl[6] = '{w: 8'sd0,   p: 8'sd100, relu: 1'b0, exp: 16'sd0};
        tbl[7] = '{w: 8'sd3,   p: 8'sd5,   relu: 1'b1, exp: 16'sd135};

        do_reset();

        for (int v = 0; v < NV; v++) send_uniform(tbl[v], v == 0);
        drain();
        check("first_out_latency", first_out_cyc - acc14, 2);
        check("table_out_count", q1_data.size(), NV * NOUT);
        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < NOUT; i++) begin
                if (q1_data.size() > 0) begin
                    d = q1_data.pop_front();
                    l = q1_last.pop_front();
                    check($sformatf("vec%0d_out%0d", v, i), d, tbl[v].exp);
                    check($sformatf("vec%0d_last%0d", v, i), l, (i == NOUT - 1) ? 1 : 0);
                end
            end
        end

        // Hold out_ready low for 5 cycles on the first result of a ramp frame.
        q1_data.delete();
        q1_last.delete();
        fork
            send_ramp();
            begin
                g = 0;
                while (!out_valid1 && g < 100) begin
                    @(posedge clk); #1;
                    g++;
                end
                check("stall_saw_valid", out_valid1, 1);
                out_ready = 1'b0;
                held = data_out1;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_data_hold", data_out1, held);
                    check("stall_in_ready", in_ready1, 0);
                    check("stall_valid_hold", out_valid1, 1);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check_ramp_q1("stall");

        // Partial frame of -50s, reset, then a clean ramp frame.
        weight_value = {K*K{8'sd1}};
        relu_en = 1'b0;
        for (int i = 0; i < 20; i++) push(-8'sd50);
        do_reset();
        q1_data.delete();
        q1_last.delete();
        send_ramp();
        drain();
        check_ramp_q1("rstramp");

        q2_data.delete();
        q2_last.delete();
        sel2 = 1'b1;
        send_ramp();
        drain();
        sel2 = 1'b0;
        check("s2_count", q2_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (q2_data.size() > 0) begin
                d = q2_data.pop_front();
                l = q2_last.pop_front();
                check($sformatf("s2_out%0d", i), d, ramp_exp(2 * (i / 2), 2 * (i % 2)));
                check($sformatf("s2_last%0d", i), l, (i == 3) ? 1 : 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
